// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: absorbs up-to-8-word icache returns and feeds
// decode up to two instructions (with PCs) per cycle, with single-cycle flush.
module inst_fetch_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [255:0]      in_data,
    input  logic [3:0]        in_num,
    input  logic [31:0]       in_pc,
    output logic              out_valid0,
    output logic              out_valid1,
    output logic [31:0]       out_inst0,
    output logic [31:0]       out_inst1,
    output logic [31:0]       out_pc0,
    output logic [31:0]       out_pc1,
    input  logic [1:0]        out_pop,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned MAX_W = 8;

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [31:0] inst_q [DEPTH];
    logic [31:0] inst_d [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] pc_d   [DEPTH];

    logic              push;
    logic [3:0]        push_n;
    logic [1:0]        pop_req;
    logic [1:0]        pop_p;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] head1;

    // Threshold on registered occupancy guarantees room for a full 8-word return.
    assign in_ready = (cnt_q <= CW'(DEPTH - MAX_W));
    assign push     = in_valid && in_ready && !flush;

    // Pointer and occupancy update
    always_comb begin
        push_n  = '0;
        if (push) begin
            push_n = (in_num > 4'd8) ? 4'd8 : in_num;
        end
        pop_req = (out_pop == 2'd3) ? 2'd2 : out_pop;
        pop_p   = (CW'(pop_req) > cnt_q) ? cnt_q[1:0] : pop_req;
        head_d  = head_q + ADDR_W'(pop_p);
        tail_d  = tail_q + ADDR_W'(push_n);
        cnt_d   = cnt_q + CW'(push_n) - CW'(pop_p);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    // Each entry picks its word by its distance from tail; wraps naturally.
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inst_d[i] = inst_q[i];
            pc_d[i]   = pc_q[i];
            off       = ADDR_W'(i) - tail_q;
            if (CW'(off) < CW'(push_n)) begin
                inst_d[i] = in_data[{off[2:0], 5'd0} +: 32];
                pc_d[i]   = in_pc + (32'(off) << 2);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage carries no reset; validity comes from cnt_q alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= inst_d[i];
            pc_q[i]   <= pc_d[i];
        end
    end

    assign head1      = head_q + ADDR_W'(1);
    assign out_valid0 = (cnt_q != '0);
    assign out_valid1 = (cnt_q >= CW'(2));
    assign out_inst0  = out_valid0 ? inst_q[head_q] : '0;
    assign out_pc0    = out_valid0 ? pc_q[head_q]   : '0;
    assign out_inst1  = out_valid1 ? inst_q[head1]  : '0;
    assign out_pc1    = out_valid1 ? pc_q[head1]    : '0;
    assign count      = cnt_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table plus hand sequences for
// asynchronous reset and push-to-output latency.
module tb_inst_fetch_queue;

    logic         clk;
    logic         resetn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [3:0]   in_num;
    logic [31:0]  in_pc;
    logic         out_valid0, out_valid1;
    logic [31:0]  out_inst0, out_inst1, out_pc0, out_pc1;
    logic [1:0]   out_pop;
    logic [4:0]   count;

    int n_tests;
    int n_fail;

    inst_fetch_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_num(in_num), .in_pc(in_pc),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_pop(out_pop), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        vld;
        logic [3:0]  num;
        logic [31:0] pc;
        logic [31:0] base;
        logic [1:0]  pop;
        logic [4:0]  cnt;
        logic        rdy;
        logic        v0;
        logic        v1;
        logic [31:0] i0;
        logic [31:0] p0;
        logic [31:0] i1;
        logic [31:0] p1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic vld, logic [3:0] num, logic [31:0] pc,
                                logic [31:0] base, logic [1:0] pop, logic [4:0] cnt,
                                logic rdy, logic v0, logic v1, logic [31:0] i0,
                                logic [31:0] p0, logic [31:0] i1, logic [31:0] p1);
        vec_t v;
        v.fl = fl; v.vld = vld; v.num = num; v.pc = pc; v.base = base; v.pop = pop;
        v.cnt = cnt; v.rdy = rdy; v.v0 = v0; v.v1 = v1;
        v.i0 = i0; v.p0 = p0; v.i1 = i1; v.p1 = p1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic vld, input logic [3:0] num,
                         input logic [31:0] pc, input logic [31:0] base, input logic [1:0] pop);
        flush    = fl;
        in_valid = vld;
        in_num   = num;
        in_pc    = pc;
        out_pop  = pop;
        for (int k = 0; k < 8; k++) in_data[32*k +: 32] = base + 32'(k);
    endtask

    task automatic chk_all(input string tag, input logic [4:0] cnt, input logic rdy,
                           input logic v0, input logic v1, input logic [31:0] i0,
                           input logic [31:0] p0, input logic [31:0] i1, input logic [31:0] p1);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".out_valid0"}, 32'(out_valid0), 32'(v0));
        chk({tag, ".out_valid1"}, 32'(out_valid1), 32'(v1));
        chk({tag, ".out_inst0"}, out_inst0, i0);
        chk({tag, ".out_pc0"}, out_pc0, p0);
        chk({tag, ".out_inst1"}, out_inst1, i1);
        chk({tag, ".out_pc1"}, out_pc1, p1);
    endtask

    // Protocol monitor: a non-flushed return offered while the queue is not ready.
    always @(negedge clk) begin
        if (resetn && in_valid && !in_ready && !flush) begin
            n_tests++;
            n_fail++;
            $display("FAIL protocol: in_valid=1 while in_ready=0 at %0t", $time);
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 2'd0);

        // fl vld num pc base pop | cnt rdy v0 v1 i0 p0 i1 p1
        vecs.push_back(mk(0,1,4'd8,32'hBFC00000,32'h1000,2'd0, 5'd8,1,1,1, 32'h1000,32'hBFC00000,32'h1001,32'hBFC00004));
        vecs.push_back(mk(0,1,4'd8,32'hBFC00020,32'h1008,2'd0, 5'd16,0,1,1, 32'h1000,32'hBFC00000,32'h1001,32'hBFC00004));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd14,0,1,1, 32'h1002,32'hBFC00008,32'h1003,32'hBFC0000C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd12,0,1,1, 32'h1004,32'hBFC00010,32'h1005,32'hBFC00014));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd10,0,1,1, 32'h1006,32'hBFC00018,32'h1007,32'hBFC0001C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd8,1,1,1, 32'h1008,32'hBFC00020,32'h1009,32'hBFC00024));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd6,1,1,1, 32'h100A,32'hBFC00028,32'h100B,32'hBFC0002C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd4,1,1,1, 32'h100C,32'hBFC00030,32'h100D,32'hBFC00034));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd2,1,1,1, 32'h100E,32'hBFC00038,32'h100F,32'hBFC0003C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd0,1,0,0, 32'h0,32'h0,32'h0,32'h0));
        // walk head/tail to 12, including out_pop=3 treated as 2
        vecs.push_back(mk(0,1,4'd8,32'h100,32'h2000,2'd0, 5'd8,1,1,1, 32'h2000,32'h100,32'h2001,32'h104));
        vecs.push_back(mk(0,1,4'd4,32'h120,32'h2008,2'd2, 5'd10,0,1,1, 32'h2002,32'h108,32'h2003,32'h10C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd3, 5'd8,1,1,1, 32'h2004,32'h110,32'h2005,32'h114));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd6,1,1,1, 32'h2006,32'h118,32'h2007,32'h11C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd4,1,1,1, 32'h2008,32'h120,32'h2009,32'h124));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd2,1,1,1, 32'h200A,32'h128,32'h200B,32'h12C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd0,1,0,0, 32'h0,32'h0,32'h0,32'h0));
        // wrapping push into entries 12..15,0,1
        vecs.push_back(mk(0,1,4'd6,32'h80000000,32'h3000,2'd0, 5'd6,1,1,1, 32'h3000,32'h80000000,32'h3001,32'h80000004));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd4,1,1,1, 32'h3002,32'h80000008,32'h3003,32'h8000000C));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd2,1,1,1, 32'h3004,32'h80000010,32'h3005,32'h80000014));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd0,1,0,0, 32'h0,32'h0,32'h0,32'h0));
        // in_num saturation and PC wrapping modulo 2^32
        vecs.push_back(mk(0,1,4'd15,32'hFFFFFFF8,32'h4000,2'd0, 5'd8,1,1,1, 32'h4000,32'hFFFFFFF8,32'h4001,32'hFFFFFFFC));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd6,1,1,1, 32'h4002,32'h0,32'h4003,32'h4));
        vecs.push_back(mk(0,1,4'd0,32'h700,32'h7700,2'd0, 5'd6,1,1,1, 32'h4002,32'h0,32'h4003,32'h4));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd4,1,1,1, 32'h4004,32'h8,32'h4005,32'hC));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd2, 5'd2,1,1,1, 32'h4006,32'h10,32'h4007,32'h14));
        vecs.push_back(mk(0,0,4'd0,32'h0,32'h0,2'd1, 5'd1,1,1,0, 32'h4007,32'h14,32'h0,32'h0));
        // cnt=1, pop 2 with push 3: only one consumed
        vecs.push_back(mk(0,1,4'd3,32'h200,32'h5000,2'd2, 5'd3,1,1,1, 32'h5000,32'h200,32'h5001,32'h204));
        vecs.push_back(mk(0,1,4'd8,32'h300,32'h6000,2'd1, 5'd10,0,1,1, 32'h5001,32'h204,32'h5002,32'h208));
        // flush beats same-cycle push and pop
        vecs.push_back(mk(1,1,4'd4,32'h900,32'h9900,2'd2, 5'd0,1,0,0, 32'h0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,4'd1,32'h400,32'h7000,2'd0, 5'd1,1,1,0, 32'h7000,32'h400,32'h0,32'h0));

        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_all("reset", 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].vld, vecs[i].num, vecs[i].pc, vecs[i].base, vecs[i].pop);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rdy, vecs[i].v0, vecs[i].v1,
                    vecs[i].i0, vecs[i].p0, vecs[i].i1, vecs[i].p1);
        end

        // Push offered, then asynchronous reset between edges; no same-cycle bypass.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd2, 32'h600, 32'h9000, 2'd0);
        #1;
        chk("nobypass.out_inst0", out_inst0, 32'h7000);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("async_rst", 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("rst_hold", 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 2'd0);
        resetn = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd1, 32'h500, 32'h8000, 2'd0);
        #1;
        chk("latency.out_valid0", 32'(out_valid0), 32'h0);
        @(posedge clk);
        #1;
        chk_all("post_rst", 5'd1, 1'b1, 1'b1, 1'b0, 32'h8000, 32'h500, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 2'd0);
        @(posedge clk);
        #1;
        chk("idle.count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
